branch_predict_unit: RTL and testbench

//  Fetch-side branch predictor and EX-side resolver. It produces the predicted

---
 rtl/branch_predict_unit_if.sv | 25 ++
 rtl/branch_predict_unit.sv | 140 ++++++++++++++
 tb/tb_branch_predict_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_unit_if.sv
// Fetch/resolve port bundle for branch_predict_unit: IF-side lookup, EX-side resolution
// and the misprediction restore outputs.
interface branch_predict_unit_if;
  logic        stall_if;
  logic [31:0] pc_if;
  logic        pred_taken_if;
  logic [31:0] pred_target_if;
  logic        ex_inst_valid;
  logic        ex_valid;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] ex_pc;
  logic        missPrediction;
  logic [31:0] Target_PC_ID;

  modport slave (
    input  stall_if, pc_if, ex_inst_valid, ex_valid, ex_taken, ex_target, ex_pc,
    output pred_taken_if, pred_target_if, missPrediction, Target_PC_ID
  );

  modport master (
    output stall_if, pc_if, ex_inst_valid, ex_valid, ex_taken, ex_target, ex_pc,
    input  pred_taken_if, pred_target_if, missPrediction, Target_PC_ID
  );
endinterface

// File: rtl/branch_predict_unit.sv
// BTB + 2-bit counter branch predictor with IF->ID->EX prediction pipe and EX resolver.
// Optional gshare indexing is enabled with the GSHARE_EN macro.
module branch_predict_unit #(
  parameter int ENTRIES  = 16,
  parameter int GHR_BITS = 4
) (
  input logic                   clk,
  input logic                   reset,
  branch_predict_unit_if.slave  bp
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } entry_t;

  typedef struct packed {
    logic           taken;
    logic [31:0]    target;
    logic [IDX-1:0] idx;
  } stage_t;

  entry_t tbl_q [ENTRIES];
  entry_t tbl_d [ENTRIES];
  stage_t id_q, id_d;
  stage_t ex_q, ex_d;

  logic [IDX-1:0] idx_if;
  entry_t         ent_if;
  logic           hit_if;
  logic           pred_taken_raw;
  logic [31:0]    pred_target_raw;

  entry_t         ent_ex;
  entry_t         ent_upd;
  logic           hit_ex;
  logic           alias_ex;
  logic           miss_raw;
  logic [31:0]    tpc_raw;

`ifdef GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [IDX-1:0]      ghr_ext;

  assign ghr_ext = IDX'(ghr_q);
  assign idx_if  = bp.pc_if[IDX+1:2] ^ ghr_ext;

  // History is updated only by resolved branches, so it never needs repair on a miss.
  always_comb begin
    ghr_d = ghr_q;
    if (bp.ex_valid) ghr_d = GHR_BITS'({ghr_q, bp.ex_taken});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end
`else
  assign idx_if = bp.pc_if[IDX+1:2];
`endif

  // IF lookup reads the pre-update table contents; no bypass from the EX write.
  always_comb begin
    ent_if          = tbl_q[idx_if];
    hit_if          = ent_if.valid && (ent_if.tag == bp.pc_if[31:IDX+2]);
    pred_taken_raw  = hit_if && ent_if.ctr[1];
    pred_target_raw = pred_taken_raw ? ent_if.target : bp.pc_if + 32'd4;
  end

  always_comb begin
    ent_ex   = tbl_q[ex_q.idx];
    hit_ex   = ent_ex.valid && (ent_ex.tag == bp.ex_pc[31:IDX+2]);
    alias_ex = bp.ex_inst_valid && !bp.ex_valid && ex_q.taken;
    if (bp.ex_valid)
      miss_raw = (bp.ex_taken != ex_q.taken) ||
                 (bp.ex_taken && (bp.ex_target != ex_q.target));
    else
      miss_raw = alias_ex;
    tpc_raw = (bp.ex_valid && bp.ex_taken) ? bp.ex_target : bp.ex_pc + 32'd4;
  end

  assign bp.pred_taken_if  = reset && pred_taken_raw;
  assign bp.pred_target_if = reset ? pred_target_raw : 32'd0;
  assign bp.missPrediction = reset && miss_raw;
  assign bp.Target_PC_ID   = (reset && miss_raw) ? tpc_raw : 32'd0;

  // A miss flushes both stages; flush wins over stall.
  always_comb begin
    id_d = id_q;
    ex_d = ex_q;
    if (miss_raw) begin
      id_d = '0;
      ex_d = '0;
    end else if (!bp.stall_if) begin
      id_d = '{taken: pred_taken_raw, target: pred_target_raw, idx: idx_if};
      ex_d = id_q;
    end
  end

  always_comb begin
    tbl_d   = tbl_q;
    ent_upd = ent_ex;
    if (bp.ex_valid && hit_ex) begin
      if (bp.ex_taken) begin
        if (ent_upd.ctr != 2'b11) ent_upd.ctr = ent_upd.ctr + 2'd1;
        ent_upd.target = bp.ex_target;
      end else if (ent_upd.ctr != 2'b00) begin
        ent_upd.ctr = ent_upd.ctr - 2'd1;
      end
    end else if (bp.ex_valid && bp.ex_taken) begin
      ent_upd.valid  = 1'b1;
      ent_upd.tag    = bp.ex_pc[31:IDX+2];
      ent_upd.target = bp.ex_target;
      ent_upd.ctr    = 2'b10;
    end else if (alias_ex) begin
      ent_upd.valid = 1'b0;
    end
    tbl_d[ex_q.idx] = ent_upd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
      end
      id_q <= '0;
      ex_q <= '0;
    end else begin
      tbl_q <= tbl_d;
      id_q  <= id_d;
      ex_q  <= ex_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_branch_predict_unit;
  localparam logic [31:0] FILL = 32'h0000_1000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if bif();

  branch_predict_unit #(.ENTRIES(16), .GHR_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bif)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic expect_out(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       act = {31'b0, bif.pred_taken_if};
        1:       act = bif.pred_target_if;
        2:       act = {31'b0, bif.missPrediction};
        default: act = bif.Target_PC_ID;
      endcase
      tests_run++;
      if (act !== e.exp) begin
        tests_failed++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    bif.ex_inst_valid = 1'b0;
    bif.ex_valid      = 1'b0;
    bif.ex_taken      = 1'b0;
    bif.ex_target     = 32'd0;
    bif.ex_pc         = 32'd0;
  endtask

  task automatic fetch_chk(input string n, input logic [31:0] pc,
                           input logic tk, input logic [31:0] tg);
    bif.pc_if = pc;
    expect_out({n, ".pred_taken"}, 0, {31'b0, tk});
    expect_out({n, ".pred_target"}, 1, tg);
  endtask

  task automatic resolve_chk(input string n, input logic iv, input logic v, input logic t,
                             input logic [31:0] tgt, input logic [31:0] pc,
                             input logic m, input logic [31:0] tpc);
    bif.ex_inst_valid = iv;
    bif.ex_valid      = v;
    bif.ex_taken      = t;
    bif.ex_target     = tgt;
    bif.ex_pc         = pc;
    expect_out({n, ".miss"}, 2, {31'b0, m});
    expect_out({n, ".target_pc"}, 3, tpc);
  endtask

  // Fetch pc, let it travel IF->ID->EX behind a filler fetch, then resolve it.
  task automatic branch(input string n, input logic [31:0] pc,
                        input logic ptk, input logic [31:0] ptg,
                        input logic iv, input logic v, input logic t, input logic [31:0] tgt,
                        input logic m, input logic [31:0] tpc);
    idle_ex();
    fetch_chk(n, pc, ptk, ptg);
    cyc();
    bif.pc_if = FILL;
    cyc();
    resolve_chk(n, iv, v, t, tgt, pc, m, tpc);
    cyc();
    idle_ex();
  endtask

  initial begin
    bif.stall_if = 1'b0;
    bif.pc_if    = 32'h100;
    // Ungated these inputs would give a nonzero target and a miss.
    bif.ex_inst_valid = 1'b1;
    bif.ex_valid      = 1'b1;
    bif.ex_taken      = 1'b1;
    bif.ex_target     = 32'h80;
    bif.ex_pc         = 32'h100;
    expect_out("in_reset.pred_taken", 0, 32'd0);
    expect_out("in_reset.pred_target", 1, 32'd0);
    expect_out("in_reset.miss", 2, 32'd0);
    expect_out("in_reset.target_pc", 3, 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    idle_ex();
    cyc();

`ifdef GSHARE_EN
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        idle_ex(); bif.pc_if = 32'h200; cyc(); bif.pc_if = FILL; cyc();
        bif.ex_inst_valid = 1'b1; bif.ex_valid = 1'b1; bif.ex_taken = 1'b1;
        bif.ex_target = 32'h240; bif.ex_pc = 32'h200; cyc(); idle_ex();
      end else begin
        idle_ex(); bif.pc_if = 32'h200; cyc(); bif.pc_if = FILL; cyc();
        bif.ex_inst_valid = 1'b1; bif.ex_valid = 1'b1; bif.ex_taken = 1'b0;
        bif.ex_target = 32'h0; bif.ex_pc = 32'h200; cyc(); idle_ex();
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        branch($sformatf("gshare_t%0d", i), 32'h200, 1'b1, 32'h240,
               1'b1, 1'b1, 1'b1, 32'h240, 1'b0, 32'h0);
      else
        branch($sformatf("gshare_n%0d", i), 32'h200, 1'b0, 32'h204,
               1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    end
`else
    branch("cold",       32'h100, 1'b0, 32'h104, 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80);
    branch("train1",     32'h100, 1'b1, 32'h80,  1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    branch("train2",     32'h100, 1'b1, 32'h80,  1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    branch("flip",       32'h100, 1'b1, 32'h80,  1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h104);
    branch("after_flip", 32'h100, 1'b1, 32'h80,  1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    branch("retarget",   32'h100, 1'b1, 32'h80,  1'b1, 1'b1, 1'b1, 32'h90, 1'b1, 32'h90);
    branch("wrap",       32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    branch("alias_nohit", 32'h140, 1'b0, 32'h144, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    branch("alias_hit",   32'h100, 1'b1, 32'h90,  1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h104);
    branch("alias_gone",  32'h100, 1'b0, 32'h104, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    branch("realloc",     32'h100, 1'b0, 32'h104, 1'b1, 1'b1, 1'b1, 32'h90, 1'b1, 32'h90);

    // Taken prediction parked in ID across a 3-cycle stall.
    idle_ex();
    fetch_chk("stall_fetch", 32'h100, 1'b1, 32'h90);
    cyc();
    bif.pc_if = FILL;
    bif.stall_if = 1'b1;
    cyc(); cyc(); cyc();
    bif.stall_if = 1'b0;
    cyc();
    resolve_chk("stall_ex", 1'b1, 1'b1, 1'b1, 32'h90, 32'h100, 1'b0, 32'h0);
    cyc();
    idle_ex();

    // Back-to-back taken predictions; the miss on the first must flush the second.
    fetch_chk("flush_f1", 32'h100, 1'b1, 32'h90);
    cyc();
    fetch_chk("flush_f2", 32'h100, 1'b1, 32'h90);
    cyc();
    bif.pc_if = FILL;
    resolve_chk("flush_miss", 1'b1, 1'b1, 1'b0, 32'h0, 32'h100, 1'b1, 32'h104);
    cyc();
    resolve_chk("flush_clear", 1'b1, 1'b0, 1'b0, 32'h0, 32'h104, 1'b0, 32'h0);
    cyc();
    idle_ex();

    bif.stall_if = 1'b1;
    fetch_chk("pre_rst", 32'h100, 1'b1, 32'h90);
    cyc();
    bif.ex_inst_valid = 1'b1;
    bif.ex_valid      = 1'b1;
    bif.ex_taken      = 1'b1;
    bif.ex_target     = 32'h44;
    bif.ex_pc         = 32'h100;
    expect_out("rst_mid.pred_taken", 0, 32'd0);
    expect_out("rst_mid.pred_target", 1, 32'd0);
    expect_out("rst_mid.miss", 2, 32'd0);
    expect_out("rst_mid.target_pc", 3, 32'd0);
    #2 reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    bif.stall_if = 1'b0;
    idle_ex();
    cyc();
    branch("post_rst", 32'h100, 1'b0, 32'h104, 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80);
`endif

    cyc();
    cyc();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
